mem_end_tracker: RTL and testbench

//  Memory-side producer of the per-interface "memory done" token that the function-exit sync block joins on.
//  - Tracks stores announced by control blocks against store completions from the memory port.
//  - Accepts the control-end token.
//  - Raises memEnd_valid once control has ended and no store is outstanding.
//  - Returns to RUN after the handshake, so the block is reusable across kernel invocations.

---
 rtl/mem_end_pkg.sv | 19 +
 rtl/mem_end_if.sv | 31 +++
 rtl/popcount_n.sv | 21 ++
 rtl/mem_end_tracker.sv | 120 ++++++++++++
 tb/tb_mem_end_tracker.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_end_pkg.sv
// Shared definitions for the memory-end tracker.
// State encodings and a constant-width helper.
package mem_end_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_end_if.sv
// Handshake bundle between control, memory port and the exit sync block.
// The tracker uses the slave view; its environment uses the master view.
interface mem_end_if #(
    parameter int NUM_CTRL    = 2,
    parameter int NUM_STORES  = 2,
    parameter int COUNT_WIDTH = 16
);

    logic [NUM_CTRL-1:0]             ctrl_valid;
    logic [NUM_CTRL*COUNT_WIDTH-1:0] ctrl_data;
    logic [NUM_CTRL-1:0]             ctrl_ready;
    logic [NUM_STORES-1:0]           st_done;
    logic                            ctrlEnd_valid;
    logic                            ctrlEnd_ready;
    logic                            memEnd_valid;
    logic                            memEnd_ready;
    logic                            err;

    modport master (
        output ctrl_valid, ctrl_data, st_done,
        output ctrlEnd_valid, memEnd_ready,
        input  ctrl_ready, ctrlEnd_ready, memEnd_valid, err
    );

    modport slave (
        input  ctrl_valid, ctrl_data, st_done,
        input  ctrlEnd_valid, memEnd_ready,
        output ctrl_ready, ctrlEnd_ready, memEnd_valid, err
    );

endinterface

// File: rtl/popcount_n.sv
// Combinational population count of a strobe vector.
// Output is wide enough to hold SIZE.
module popcount_n
    import mem_end_pkg::*;
#(
    parameter  int SIZE = 2,
    localparam int OW   = (clog2(SIZE + 1) < 1) ? 1 : clog2(SIZE + 1)
) (
    input  logic [SIZE-1:0] bits_i,
    output logic [OW-1:0]   count_o
);

    // Sum the individual strobe bits.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < SIZE; i++) begin
            count_o = count_o + OW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/mem_end_tracker.sv
// Counts announced stores against retired stores and raises memEnd
// once control has ended and nothing is outstanding.
module mem_end_tracker
    import mem_end_pkg::*;
#(
    parameter int NUM_CTRL    = 2,
    parameter int NUM_STORES  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    mem_end_if.slave bus
);

    localparam int CW  = COUNT_WIDTH;
    localparam int SW  = CW + clog2(NUM_CTRL + 1);
    localparam int NW  = SW + 1;
    localparam int PW0 = clog2(NUM_STORES + 1);
    localparam int PW  = (PW0 < 1) ? 1 : PW0;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       pending_q, pending_d;
    logic                err_q, err_d;

    logic                ctrl_rdy;
    logic                end_rdy;
    logic                end_hs;
    logic [NUM_CTRL-1:0] accept;
    logic [SW-1:0]       sum;
    logic [PW-1:0]       done_cnt;
    logic [NW-1:0]       total;
    logic [NW-1:0]       diff;
    logic [CW-1:0]       pend_next;
    logic                clip;

    popcount_n #(.SIZE(NUM_STORES)) u_pop (
        .bits_i  (bus.st_done),
        .count_o (done_cnt)
    );

    // Readies are held low while reset is asserted.
    assign ctrl_rdy = rst && (state_q != ST_DONE);
    assign end_rdy  = rst && (state_q == ST_RUN);
    assign end_hs   = bus.ctrlEnd_valid && end_rdy;
    assign accept   = bus.ctrl_valid & {NUM_CTRL{ctrl_rdy}};

    assign bus.ctrl_ready    = {NUM_CTRL{ctrl_rdy}};
    assign bus.ctrlEnd_ready = end_rdy;
    assign bus.memEnd_valid  = (state_q == ST_DONE);
    assign bus.err           = err_q;

    // Adder tree over accepted control channels.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (accept[i]) begin
                sum = sum + SW'(bus.ctrl_data[i*CW +: CW]);
            end
        end
    end

    // Net arrivals and retirements, saturating to the counter range.
    always_comb begin
        total     = NW'(pending_q) + NW'(sum);
        diff      = '0;
        pend_next = '0;
        clip      = 1'b0;
        if (total < NW'(done_cnt)) begin
            clip = 1'b1;
        end else begin
            diff = total - NW'(done_cnt);
            if (diff > NW'({CW{1'b1}})) begin
                pend_next = {CW{1'b1}};
                clip      = 1'b1;
            end else begin
                pend_next = diff[CW-1:0];
            end
        end
    end

    // Next state, pending count and sticky error.
    always_comb begin
        state_d   = state_q;
        pending_d = pend_next;
        err_d     = err_q || clip ||
                    ((state_q == ST_DRAIN) && (|accept));
        case (state_q)
            ST_RUN: begin
                if (end_hs) begin
                    state_d = (pend_next == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pend_next == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.memEnd_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_end_tracker.sv
// Directed bench for mem_end_tracker.
// Each scenario task drives vectors and checks hand-computed results.
module tb_mem_end_tracker;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_end_if #(.NUM_CTRL(2), .NUM_STORES(2), .COUNT_WIDTH(16)) bus ();

    mem_end_tracker #(
        .NUM_CTRL(2), .NUM_STORES(2), .COUNT_WIDTH(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ctrl_valid    = 2'b00;
        bus.ctrl_data     = '0;
        bus.st_done       = 2'b00;
        bus.ctrlEnd_valid = 1'b0;
        bus.memEnd_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ctrl_valid    = 2'b11;
        bus.ctrl_data     = '1;
        bus.st_done       = 2'b11;
        bus.ctrlEnd_valid = 1'b1;
        bus.memEnd_ready  = 1'b1;
        step();
        step();
        total++;
        if (bus.memEnd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_memEnd got=%b exp=0", bus.memEnd_valid);
        end
        total++;
        if (bus.ctrl_ready !== 2'b00 || bus.ctrlEnd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b/%b exp=00/0",
                     bus.ctrl_ready, bus.ctrlEnd_ready);
        end
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b exp=0", bus.err);
        end
        idle();
        rst = 1'b1;
        #1;
        total++;
        if (bus.ctrl_ready !== 2'b11 || bus.ctrlEnd_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready got=%b/%b exp=11/1",
                     bus.ctrl_ready, bus.ctrlEnd_ready);
        end
    endtask

    task automatic test_basic_drain();
        do_reset();
        bus.ctrl_valid = 2'b01;
        bus.ctrl_data  = {16'd0, 16'd3};
        step();
        bus.ctrl_valid    = 2'b00;
        bus.ctrlEnd_valid = 1'b1;
        total++;
        if (dut.pending_q !== 16'd3) begin
            bad++;
            $display("FAIL drain_pending3 got=%0d exp=3", dut.pending_q);
        end
        step();
        bus.ctrlEnd_valid = 1'b0;
        bus.st_done       = 2'b01;
        total++;
        if (dut.state_q !== S_DRAIN) begin
            bad++;
            $display("FAIL drain_state got=%0d exp=%0d", dut.state_q, S_DRAIN);
        end
        step();
        step();
        total++;
        if (dut.pending_q !== 16'd1 || bus.memEnd_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_t4 got=%0d/%b exp=1/0",
                     dut.pending_q, bus.memEnd_valid);
        end
        step();
        bus.st_done = 2'b00;
        total++;
        if (bus.memEnd_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_memEnd got=%b exp=1", bus.memEnd_valid);
        end
        step();
        step();
        total++;
        if (bus.memEnd_valid !== 1'b1 || bus.ctrl_ready !== 2'b00) begin
            bad++;
            $display("FAIL drain_hold got=%b/%b exp=1/00",
                     bus.memEnd_valid, bus.ctrl_ready);
        end
        bus.memEnd_ready = 1'b1;
        step();
        bus.memEnd_ready = 1'b0;
        total++;
        if (dut.state_q !== S_RUN || bus.memEnd_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_release got=%0d/%b exp=0/0",
                     dut.state_q, bus.memEnd_valid);
        end
    endtask

    task automatic test_immediate_end();
        do_reset();
        bus.ctrlEnd_valid = 1'b1;
        step();
        bus.ctrlEnd_valid = 1'b0;
        total++;
        if (bus.memEnd_valid !== 1'b1 || bus.ctrlEnd_ready !== 1'b0) begin
            bad++;
            $display("FAIL imm_memEnd got=%b/%b exp=1/0",
                     bus.memEnd_valid, bus.ctrlEnd_ready);
        end
        bus.memEnd_ready = 1'b1;
        step();
        bus.memEnd_ready = 1'b0;
        total++;
        if (dut.state_q !== S_RUN || bus.ctrlEnd_ready !== 1'b1 ||
            bus.memEnd_valid !== 1'b0) begin
            bad++;
            $display("FAIL imm_run got=%0d/%b/%b exp=0/1/0",
                     dut.state_q, bus.ctrlEnd_ready, bus.memEnd_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.ctrl_valid = 2'b01;
        bus.ctrl_data  = {16'd0, 16'd2};
        step();
        bus.ctrl_valid = 2'b11;
        bus.ctrl_data  = {16'd4, 16'd1};
        bus.st_done    = 2'b11;
        step();
        idle();
        total++;
        if (dut.pending_q !== 16'd5 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL simul got=%0d/%b exp=5/0", dut.pending_q, bus.err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        bus.st_done = 2'b01;
        step();
        bus.st_done = 2'b00;
        total++;
        if (dut.pending_q !== 16'd0 || bus.err !== 1'b1) begin
            bad++;
            $display("FAIL underflow got=%0d/%b exp=0/1", dut.pending_q, bus.err);
        end
        step();
        step();
        total++;
        if (bus.err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b exp=1", bus.err);
        end
        do_reset();
        bus.ctrl_valid = 2'b01;
        bus.ctrl_data  = {16'd0, 16'd2};
        step();
        bus.ctrl_valid    = 2'b00;
        bus.ctrlEnd_valid = 1'b1;
        step();
        bus.ctrlEnd_valid = 1'b0;
        total++;
        if (dut.state_q !== S_DRAIN || bus.err !== 1'b0 ||
            bus.ctrl_ready !== 2'b11) begin
            bad++;
            $display("FAIL proto_pre got=%0d/%b/%b exp=1/0/11",
                     dut.state_q, bus.err, bus.ctrl_ready);
        end
        bus.ctrl_valid = 2'b10;
        bus.ctrl_data  = {16'd1, 16'd0};
        step();
        bus.ctrl_valid = 2'b00;
        total++;
        if (dut.pending_q !== 16'd3 || bus.err !== 1'b1) begin
            bad++;
            $display("FAIL proto_drain got=%0d/%b exp=3/1",
                     dut.pending_q, bus.err);
        end
        do_reset();
        bus.ctrl_valid = 2'b11;
        bus.ctrl_data  = {16'd1, 16'hFFFF};
        step();
        bus.ctrl_valid = 2'b00;
        total++;
        if (dut.pending_q !== 16'hFFFF || bus.err !== 1'b1) begin
            bad++;
            $display("FAIL overflow got=%h/%b exp=ffff/1",
                     dut.pending_q, bus.err);
        end
    endtask

    task automatic test_reset_mid_done();
        do_reset();
        bus.ctrlEnd_valid = 1'b1;
        step();
        bus.ctrlEnd_valid = 1'b0;
        total++;
        if (bus.memEnd_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got=%b exp=1", bus.memEnd_valid);
        end
        rst = 1'b0;
        step();
        total++;
        if (bus.memEnd_valid !== 1'b0 || dut.pending_q !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%0d exp=0/0",
                     bus.memEnd_valid, dut.pending_q);
        end
        rst = 1'b1;
        bus.ctrl_valid = 2'b01;
        bus.ctrl_data  = {16'd0, 16'd1};
        step();
        bus.ctrl_valid    = 2'b00;
        bus.ctrlEnd_valid = 1'b1;
        step();
        bus.ctrlEnd_valid = 1'b0;
        bus.st_done       = 2'b10;
        step();
        bus.st_done = 2'b00;
        total++;
        if (bus.memEnd_valid !== 1'b1 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reuse got=%b/%b exp=1/0",
                     bus.memEnd_valid, bus.err);
        end
        bus.memEnd_ready = 1'b1;
        step();
        bus.memEnd_ready = 1'b0;
        total++;
        if (bus.memEnd_valid !== 1'b0 || bus.ctrlEnd_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_done got=%b/%b exp=0/1",
                     bus.memEnd_valid, bus.ctrlEnd_ready);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle();
        test_reset();
        test_basic_drain();
        test_immediate_end();
        test_simultaneous();
        test_errors();
        test_reset_mid_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
